// File: rtl/buffer_512_to_128.sv
// buffer_512_to_128: width-down converter from 512-bit words to 128-bit words.
//
// Wide words are queued in a synchronous FIFO of DEPTH entries. The head
// entry is emitted as four consecutive 128-bit words, lane 0 (bits 127:0)
// first. The narrow output is show-ahead: data_out always shows the current
// lane of the head entry, and rd_enable advances it.
//
// Handshake semantics: a write is accepted on a clock edge where
// wr_enable==1 and full==0; data_in is captured on that edge. A narrow word
// is consumed on a clock edge where rd_enable==1 and empty==0; data_out is
// valid whenever empty==0 and reads as zero otherwise. Strobes presented
// while the matching flag blocks them are ignored without side effects.
//
// Optional feature: define BUF_512_TO_128_LEVEL_EN to add the "level" output,
// the number of 128-bit words still readable (count*4 - sel).

module buffer_512_to_128 #(
    parameter int DEPTH     = 256,
    parameter int AW        = 8,
    parameter int AF_MARGIN = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic [511:0]   data_in,
    input  logic           wr_enable,
    output logic [127:0]   data_out,
    input  logic           rd_enable,
    output logic           full,
    output logic           empty,
    output logic           full_n
`ifdef BUF_512_TO_128_LEVEL_EN
    ,
    output logic [AW+2:0]  level
`endif
);

    // Thresholds expressed at the width of count so comparisons are exact.
    localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] ALMOST_LVL = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [1:0]  LAST_LANE  = 2'd3;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    sel;
    logic [511:0]  mem [DEPTH];

    logic          do_clear;
    logic          wr_accept;
    logic          rd_step;
    logic          pop;
    logic [511:0]  head;

    // Event decode: clear dominates, a full buffer refuses writes even when
    // the head entry is popped in the same cycle.
    always_comb begin
        do_clear  = !rst || clr;
        wr_accept = wr_enable && !full;
        rd_step   = rd_enable && !empty;
        pop       = rd_step && (sel == LAST_LANE);
    end

    // Storage array; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (!do_clear && wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Write pointer advances on every accepted write and wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (do_clear) begin
            wr_ptr <= '0;
        end else if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Lane select walks 0..3 across the head entry; the read pointer moves
    // only once the last lane has been consumed.
    always_ff @(posedge clk) begin
        if (do_clear) begin
            sel    <= '0;
            rd_ptr <= '0;
        end else if (rd_step) begin
            if (pop) begin
                sel    <= '0;
                rd_ptr <= rd_ptr + 1'b1;
            end else begin
                sel    <= sel + 1'b1;
            end
        end
    end

    // Entry count: whole 512-bit entries, partially read ones still count.
    always_ff @(posedge clk) begin
        if (do_clear) begin
            count <= '0;
        end else if (wr_accept && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !wr_accept) begin
            count <= count - 1'b1;
        end
    end

    // Status flags decoded straight from the registered count.
    always_comb begin
        empty  = (count == '0);
        full   = (count == FULL_LVL);
        full_n = (count >= ALMOST_LVL);
    end

    // Show-ahead narrow output: selected lane of the head entry, zero if empty.
    always_comb begin
        head     = mem[rd_ptr];
        data_out = '0;
        if (!empty) begin
            case (sel)
                2'd0:    data_out = head[127:0];
                2'd1:    data_out = head[255:128];
                2'd2:    data_out = head[383:256];
                default: data_out = head[511:384];
            endcase
        end
    end

`ifdef BUF_512_TO_128_LEVEL_EN
    // Readable narrow words: four per stored entry minus lanes already used.
    always_comb begin
        level = {count, 2'b00} - {{(AW+1){1'b0}}, sel};
    end
`endif

endmodule

// File: tb/tb_buffer_512_to_128.sv
// tb_buffer_512_to_128: directed self-checking bench for buffer_512_to_128,
// built with DEPTH=4 so fill, full and pointer-wrap cases are reachable.
// Checks of the "level" output are included when BUF_512_TO_128_LEVEL_EN
// is defined.

module tb_buffer_512_to_128;

    localparam int DEPTH     = 4;
    localparam int AW        = 2;
    localparam int AF_MARGIN = 1;

    logic          clk;
    logic          rst;
    logic          clr;
    logic [511:0]  data_in;
    logic          wr_enable;
    logic [127:0]  data_out;
    logic          rd_enable;
    logic          full;
    logic          empty;
    logic          full_n;
`ifdef BUF_512_TO_128_LEVEL_EN
    logic [AW+2:0] level;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [127:0] exp_q[$];

    buffer_512_to_128 #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .data_in   (data_in),
        .wr_enable (wr_enable),
        .data_out  (data_out),
        .rd_enable (rd_enable),
        .full      (full),
        .empty     (empty),
        .full_n    (full_n)
`ifdef BUF_512_TO_128_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Distinct, recognisable lane value for entry e, lane k.
    function automatic logic [127:0] lane_val(input int e, input int k);
        return {32'hC0DE0000 + 32'(e), 32'(k), 32'hFEED0000 + 32'(e), 32'h100 + 32'(k)};
    endfunction

    function automatic logic [511:0] entry_val(input int e);
        return {lane_val(e, 3), lane_val(e, 2), lane_val(e, 1), lane_val(e, 0)};
    endfunction

    // Driver: one write strobe.
    task automatic write_word(input logic [511:0] d);
        data_in   = d;
        wr_enable = 1'b1;
        tick();
        wr_enable = 1'b0;
    endtask

    // Driver: check the shown narrow word, then consume it.
    task automatic read_check(input string tag, input logic [127:0] exp);
        check({tag, "_empty"}, {127'd0, empty}, 128'd0);
        check(tag, data_out, exp);
        rd_enable = 1'b1;
        tick();
        rd_enable = 1'b0;
    endtask

    // Scoreboard: push all four lanes of an entry onto the expected queue.
    task automatic expect_entry(input int e);
        for (int k = 0; k < 4; k++) exp_q.push_back(lane_val(e, k));
    endtask

    // Scoreboard: read one narrow word and compare with the queue head.
    task automatic read_scoreboard(input string tag);
        logic [127:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_underflow"}, 128'd1, 128'd0);
        end else begin
            exp = exp_q.pop_front();
            read_check(tag, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_empty"},  {127'd0, empty},  128'd1);
        check({tag, "_full"},   {127'd0, full},   128'd0);
        check({tag, "_full_n"}, {127'd0, full_n}, 128'd0);
        check({tag, "_data"},   data_out,         128'd0);
`ifdef BUF_512_TO_128_LEVEL_EN
        check({tag, "_level"},  128'(level),      128'd0);
`endif
    endtask

    initial begin
        logic [511:0] single;
        logic [511:0] x_word;

        rst       = 1'b0;
        clr       = 1'b0;
        data_in   = '0;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        x_word    = {4{128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0}};

        // Reset then idle
        tick();
        tick();
        rst = 1'b1;
        check_idle("reset");
        rd_enable = 1'b1;
        tick();
        rd_enable = 1'b0;
        check_idle("rd_while_empty");

        // Single entry: lanes A, B, C, D in order
        single = {128'hD, 128'hC, 128'hB, 128'hA};
        write_word(single);
        check("single_not_empty", {127'd0, empty}, 128'd0);
`ifdef BUF_512_TO_128_LEVEL_EN
        check("single_level4", 128'(level), 128'd4);
`endif
        read_check("single_a", 128'hA);
`ifdef BUF_512_TO_128_LEVEL_EN
        check("single_level3", 128'(level), 128'd3);
`endif
        read_check("single_b", 128'hB);
`ifdef BUF_512_TO_128_LEVEL_EN
        check("single_level2", 128'(level), 128'd2);
`endif
        read_check("single_c", 128'hC);
`ifdef BUF_512_TO_128_LEVEL_EN
        check("single_level1", 128'(level), 128'd1);
`endif
        read_check("single_d", 128'hD);
        check_idle("single_drained");

        // Fill to full, write while full is dropped
        write_word(entry_val(0));
        write_word(entry_val(1));
        check("fill2_full_n", {127'd0, full_n}, 128'd0);
        write_word(entry_val(2));
        check("fill3_full_n", {127'd0, full_n}, 128'd1);
        check("fill3_full",   {127'd0, full},   128'd0);
        write_word(entry_val(3));
        check("fill4_full",   {127'd0, full},   128'd1);
        write_word(x_word);
        check("fill5_still_full", {127'd0, full}, 128'd1);
        read_check("fill_e0_l0", lane_val(0, 0));
        read_check("fill_e0_l1", lane_val(0, 1));
        read_check("fill_e0_l2", lane_val(0, 2));
        // Pop while full with a write in the same cycle: the write is dropped.
        check("fill_e0_l3", data_out, lane_val(0, 3));
        data_in   = x_word;
        wr_enable = 1'b1;
        rd_enable = 1'b1;
        tick();
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        check("pop_while_full_full",   {127'd0, full},   128'd0);
        check("pop_while_full_full_n", {127'd0, full_n}, 128'd1);
        for (int e = 1; e < 4; e++) begin
            for (int k = 0; k < 4; k++) read_check($sformatf("fill_e%0d_l%0d", e, k), lane_val(e, k));
        end
        check_idle("fill_drained");

        // Concurrent pop of last lane and write of a new entry
        write_word(entry_val(20));
        read_check("conc_p_l0", lane_val(20, 0));
        read_check("conc_p_l1", lane_val(20, 1));
        read_check("conc_p_l2", lane_val(20, 2));
        check("conc_p_l3", data_out, lane_val(20, 3));
        data_in   = entry_val(21);
        wr_enable = 1'b1;
        rd_enable = 1'b1;
        tick();
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        check("conc_empty_stays_0", {127'd0, empty}, 128'd0);
        check("conc_full_n",        {127'd0, full_n}, 128'd0);
        check("conc_e_lane0",       data_out, lane_val(21, 0));
`ifdef BUF_512_TO_128_LEVEL_EN
        check("conc_level", 128'(level), 128'd4);
`endif
        for (int k = 0; k < 4; k++) read_check($sformatf("conc_e_l%0d", k), lane_val(21, k));
        check_idle("conc_drained");

        // Wrap-around: ten entries streamed with interleaved reads
        for (int e = 100; e < 110; e++) begin
            write_word(entry_val(e));
            expect_entry(e);
            if (e > 100) begin
                for (int k = 0; k < 4; k++) read_scoreboard($sformatf("wrap_e%0d_l%0d", e - 1, k));
            end
        end
        for (int k = 0; k < 4; k++) read_scoreboard($sformatf("wrap_last_l%0d", k));
        check("wrap_queue_drained", 128'(exp_q.size()), 128'd0);
        check_idle("wrap_drained");

        // clr mid-entry, with a write in the clearing cycle dropped
        write_word(entry_val(30));
        read_check("clr_q_l0", lane_val(30, 0));
        read_check("clr_q_l1", lane_val(30, 1));
        data_in   = entry_val(31);
        wr_enable = 1'b1;
        clr       = 1'b1;
        tick();
        clr       = 1'b0;
        wr_enable = 1'b0;
        check_idle("after_clr");
        write_word(entry_val(32));
        for (int k = 0; k < 4; k++) read_check($sformatf("clr_r_l%0d", k), lane_val(32, k));
        check_idle("clr_drained");

        // Reset mid-stream discards stored data
        write_word(entry_val(40));
        write_word(entry_val(41));
        read_check("rst_mid_l0", lane_val(40, 0));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_idle("after_mid_reset");
        write_word(entry_val(42));
        check("post_reset_lane0", data_out, lane_val(42, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
